// File: rtl/br_pkg.sv
// Shared branch-resolution types: funct3 encodings, 2-bit counter type,
// counter reset value and the saturating-counter helper.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;
  localparam ctr_t CTR_RST = CTR_WNT;

  function automatic logic f3_legal(
    input logic [2:0] f3
  );
    return f3[2:1] != 2'b01;
  endfunction

  function automatic ctr_t ctr_next(
    input ctr_t c,
    input logic taken
  );
    ctr_t n;
    n = c;
    if (taken && c != CTR_ST) begin
      n = c + 2'd1;
    end else if (!taken && c != CTR_SNT) begin
      n = c - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table of 2-bit saturating counters.
// Ports: clk_i/rst_ni (sync active-low), rd_pc_i -> rd_taken_o
// (combinational, no bypass), wr_en_i/wr_pc_i/wr_taken_i update port.
module br_bht
  import br_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_taken_o,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic            wr_taken_i
);

  localparam int IW = $clog2(ENTRIES);

  ctr_t tbl [ENTRIES];

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;

  assign rd_idx = rd_pc_i[IW+1:2];
  assign wr_idx = wr_pc_i[IW+1:2];

  assign rd_taken_o = tbl[rd_idx][1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= CTR_RST;
      end
    end else if (wr_en_i) begin
      tbl[wr_idx] <= ctr_next(tbl[wr_idx], wr_taken_i);
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc_i[XLEN-1:IW+2], rd_pc_i[1:0],
                            wr_pc_i[XLEN-1:IW+2], wr_pc_i[1:0]};

endmodule

// File: rtl/br_resolve.sv
// EX-stage branch resolution: outcome, flush/redirect, optional BHT
// predictor (BR_RESOLVE_BHT_EN) and branch/mispredict statistics.
module br_resolve
  import br_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_pred_taken_o,
  input  logic            ex_valid_i,
  input  logic            ex_stall_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jump_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic            ex_pred_taken_i,
  input  logic            br_less_i,
  input  logic            br_equal_i,
  output logic            br_unsigned_o,
  output logic            ex_taken_o,
  output logic            flush_o,
  output logic            redirect_target_o,
  output logic [31:0]     br_count_o,
  output logic [31:0]     mispred_count_o
);

  logic cond;
  logic act;
  logic upd;

  assign br_unsigned_o = ex_funct3_i[1];

  always_comb begin
    cond = 1'b0;
    case (ex_funct3_i)
      F3_BEQ:           cond = br_equal_i;
      F3_BNE:           cond = !br_equal_i;
      F3_BLT, F3_BLTU:  cond = br_less_i;
      F3_BGE, F3_BGEU:  cond = !br_less_i;
      default:          cond = 1'b0;
    endcase
  end

  always_comb begin
    ex_taken_o = 1'b0;
    if (ex_is_jump_i) begin
      ex_taken_o = 1'b1;
    end else if (ex_is_branch_i) begin
      ex_taken_o = cond;
    end
  end

  assign act = ex_valid_i & !ex_stall_i;

  assign flush_o = act & (ex_is_jump_i |
                   (ex_is_branch_i & (ex_taken_o != ex_pred_taken_i)));

  assign redirect_target_o = flush_o & ex_taken_o;

  assign upd = act & ex_is_branch_i & !ex_is_jump_i
             & f3_legal(ex_funct3_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      br_count_o      <= '0;
      mispred_count_o <= '0;
    end else if (upd) begin
      br_count_o <= br_count_o + 32'd1;
      if (flush_o) begin
        mispred_count_o <= mispred_count_o + 32'd1;
      end
    end
  end

`ifdef BR_RESOLVE_BHT_EN
  br_bht #(
    .XLEN    (XLEN),
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_pc_i    (if_pc_i),
    .rd_taken_o (if_pred_taken_o),
    .wr_en_i    (upd),
    .wr_pc_i    (ex_pc_i),
    .wr_taken_i (ex_taken_o)
  );
`else
  assign if_pred_taken_o = 1'b0;

  logic unused_pc;
  assign unused_pc = ^{if_pc_i, ex_pc_i};
`endif

endmodule

// File: doc/br_resolve.md
BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, number of predictor entries (power of two, >=2).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port if_pc_i, input, XLEN, fetch-stage PC used for prediction lookup.
REQ-006 SHALL have port if_pred_taken_o, output, 1, prediction for if_pc_i.
REQ-007 SHALL have port ex_valid_i, input, 1, EX stage holds a real instruction.
REQ-008 SHALL have port ex_stall_i, input, 1, EX stage frozen this cycle.
REQ-009 SHALL have port ex_pc_i, input, XLEN, PC of the EX instruction.
REQ-010 SHALL have port ex_is_branch_i, input, 1, EX instruction is a conditional branch.
REQ-011 SHALL have port ex_is_jump_i, input, 1, EX instruction is JAL/JALR.
REQ-012 SHALL have port ex_funct3_i, input, 3, branch funct3.
REQ-013 SHALL have port ex_pred_taken_i, input, 1, prediction carried down the pipe with the EX instruction.
REQ-014 SHALL have ports br_less_i and br_equal_i, input, 1 each, results from the branch comparator.
REQ-015 SHALL have port br_unsigned_o, output, 1, compare mode driven to the branch comparator.
REQ-016 SHALL have port ex_taken_o, output, 1, resolved outcome.
REQ-017 SHALL have port flush_o, output, 1, squash IF/ID and redirect fetch.
REQ-018 SHALL have port redirect_target_o, output, 1, 1 = fetch from the computed target, 0 = fetch from ex_pc_i+4.
REQ-019 SHALL have ports br_count_o and mispred_count_o, output, 32 each, statistics.

Function
REQ-020 SHALL drive br_unsigned_o = ex_funct3_i[1] combinationally.
REQ-021 SHALL compute ex_taken_o combinationally: 000 eq; 001 !eq; 100/110 less; 101/111 !less; 010/011 (illegal) 0; ex_is_jump_i forces 1 and takes priority over ex_is_branch_i.
REQ-022 SHALL define act = ex_valid_i & !ex_stall_i.
REQ-023 SHALL assert flush_o = act & (ex_is_jump_i | (ex_is_branch_i & ex_taken_o != ex_pred_taken_i)), in the same cycle, with zero latency.
REQ-024 SHALL set redirect_target_o = ex_taken_o whenever flush_o=1, and drive it to 0 otherwise.
REQ-025 SHALL, with the predictor enabled, keep BHT_ENTRIES 2-bit saturating counters (00 SNT, 01 WNT, 10 WT, 11 ST), indexed by pc[log2(BHT_ENTRIES)+1:2].
REQ-026 SHALL drive if_pred_taken_o = counter[idx(if_pc_i)][1], read combinationally.
REQ-027 SHALL update the counter at idx(ex_pc_i) on the clock edge when act & ex_is_branch_i & !ex_is_jump_i & legal funct3: increment if taken, decrement if not taken, saturating at 11 and 00.
REQ-028 SHALL, on a same-cycle read and write of the same index, return the pre-update value on if_pred_taken_o (no bypass).
REQ-029 SHALL increment br_count_o on every counter-update condition (REQ-027), and increment mispred_count_o when that condition holds and flush_o=1; both wrap modulo 2^32.
REQ-030 SHALL hold all state while ex_stall_i=1 or ex_valid_i=0, and SHALL drive flush_o=0 in those cycles.

Reset
REQ-031 SHALL, while rst_ni=0 at a clock edge, set every counter to 01 (WNT) and both statistic counters to 0.
REQ-032 SHALL give reset priority over any concurrent update; an update presented in the reset cycle is discarded.
REQ-033 SHALL keep its combinational outputs as defined by REQ-020..024 during reset; flush_o is not gated by reset.

Configuration
REQ-034 SHALL, when BR_RESOLVE_BHT_EN is defined, instantiate the predictor table as described.
REQ-035 SHALL, when BR_RESOLVE_BHT_EN is undefined, contain no table and tie if_pred_taken_o=0 (static not-taken); REQ-023 and the statistic counters are unchanged.

Structure
REQ-036 SHALL take the funct3 encodings, the 2-bit counter typedef and the reset value 01 from shared package br_pkg.
REQ-037 SHALL place the table in sub-module br_bht (read port, update port, synchronous reset); br_resolve instantiates it under BR_RESOLVE_BHT_EN.

Verification
REQ-038 SHALL cover: reset, then lookup of any PC -> if_pred_taken_o=0; both statistic counters=0.
REQ-039 SHALL cover: BLT (100), less=1, pred=0, valid -> ex_taken_o=1, flush_o=1, redirect_target_o=1, mispred_count_o=1 next cycle.
REQ-040 SHALL cover: BGEU (111), br_unsigned_o=1, less=0, pred=1 -> ex_taken_o=1, flush_o=0, br_count_o increments, mispred_count_o unchanged.
REQ-041 SHALL cover: three taken branches at PC 0x100 -> counter 01->10->11->11; if_pc_i=0x100 returns 1; PC 0x200 (64 entries, same index) also returns 1.
REQ-042 SHALL cover: JAL with pred=0 -> flush_o=1, redirect_target_o=1, no counter update; funct3=010 branch -> ex_taken_o=0, no update.
REQ-043 SHALL cover: mispredicting branch with ex_stall_i=1 -> flush_o=0, state unchanged; rst_ni=0 in the same cycle as an update -> counter stays 01.
